// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one EXU request at a time becomes one lsu_sram access; the loaded
// word is aligned and sign/zero-extended for writeback. `define LSU_MISALIGN_CHECK_EN adds o_misalign.

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module lsu_ctrl (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_pre_valid,
    output logic                  o_pre_ready,
    input  logic                  i_ren,
    input  logic                  i_wen,
    input  logic [2:0]            i_funct3,
    input  logic [`CPU_WIDTH-1:0] i_addr,
    input  logic [`CPU_WIDTH-1:0] i_wdata,
    input  logic [4:0]            i_rd,
    output logic                  o_post_valid,
    input  logic                  i_post_ready,
    output logic [`CPU_WIDTH-1:0] o_rdata,
    output logic [4:0]            o_rd,
    output logic                  o_mem_valid,
    output logic                  o_mem_ren,
    output logic [`CPU_WIDTH-1:0] o_mem_raddr,
    output logic                  o_mem_wen,
    output logic [`CPU_WIDTH-1:0] o_mem_waddr,
    output logic [3:0]            o_mem_wmask,
    output logic [`CPU_WIDTH-1:0] o_mem_wdata,
    input  logic [`CPU_WIDTH-1:0] i_mem_rdata,
    input  logic                  i_mem_valid
`ifdef LSU_MISALIGN_CHECK_EN
    ,
    output logic                  o_misalign
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t state, next_state;

    logic                  ren_q;
    logic                  wen_q;
    logic [2:0]            funct3_q;
    logic [`CPU_WIDTH-1:0] addr_q;
    logic [`CPU_WIDTH-1:0] wdata_q;
    logic [4:0]            rd_q;
    logic [`CPU_WIDTH-1:0] rdata_q;

    logic                  accept;
    logic                  is_mem;
    logic                  skip_mem;
    logic [3:0]            byte_mask;
    logic [`CPU_WIDTH-1:0] shifted;
    logic [`CPU_WIDTH-1:0] load_data;

    assign accept = i_pre_valid && (state == IDLE);
    assign is_mem = i_ren || i_wen;

`ifdef LSU_MISALIGN_CHECK_EN
    logic misalign_in;
    logic misalign_q;

    assign misalign_in = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                         ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
    assign skip_mem    = is_mem && misalign_in;
    assign o_misalign  = misalign_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            misalign_q <= 1'b0;
        end else if (accept) begin
            misalign_q <= skip_mem;
        end
    end
`else
    assign skip_mem = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        o_pre_ready  = 1'b0;
        o_post_valid = 1'b0;
        o_mem_valid  = 1'b0;
        o_mem_ren    = 1'b0;
        o_mem_wen    = 1'b0;
        case (state)
            IDLE: begin
                o_pre_ready = 1'b1;
                if (accept) begin
                    next_state = (is_mem && !skip_mem) ? REQ : RESP;
                end
            end
            REQ: begin
                o_mem_valid = 1'b1;
                o_mem_ren   = ren_q;
                o_mem_wen   = wen_q;
                next_state  = WAIT;
            end
            WAIT: begin
                if (i_mem_valid) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                o_post_valid = 1'b1;
                if (i_post_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // A store wins when both ren and wen are raised; rdata is cleared on accept so that
    // stores, pass-throughs and skipped accesses all answer with zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 5'd0;
            rdata_q  <= '0;
        end else if (accept) begin
            ren_q    <= i_ren && !i_wen;
            wen_q    <= i_wen;
            funct3_q <= i_funct3;
            addr_q   <= i_addr;
            wdata_q  <= i_wdata;
            rd_q     <= i_rd;
            rdata_q  <= '0;
        end else if ((state == WAIT) && i_mem_valid && ren_q) begin
            rdata_q  <= load_data;
        end
    end

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   byte_mask = 4'b0001 << addr_q[1:0];
            2'b01:   byte_mask = 4'b0011 << {addr_q[1], 1'b0};
            default: byte_mask = 4'b1111;
        endcase
    end

    assign o_mem_raddr = {addr_q[`CPU_WIDTH-1:2], 2'b00};
    assign o_mem_waddr = {addr_q[`CPU_WIDTH-1:2], 2'b00};
    assign o_mem_wmask = wen_q ? byte_mask : 4'b0000;
    assign o_mem_wdata = wdata_q << {addr_q[1:0], 3'b000};

    assign shifted = i_mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    assign o_rdata = rdata_q;
    assign o_rd    = rd_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a table of single transactions with the memory answering at
// minimum latency, plus sequences for pass-through, backpressure, reset abort and misalignment.

module tb_lsu_ctrl;

    typedef struct {
        logic        ren;
        logic        wen;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem_rdata;
        logic [4:0]  rd;
        logic [31:0] exp_addr;
        logic        exp_ren;
        logic        exp_wen;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        pre_valid;
    logic        pre_ready;
    logic        ren;
    logic        wen;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        post_valid;
    logic        post_ready;
    logic [31:0] rdata;
    logic [4:0]  rd_out;
    logic        mem_valid_out;
    logic        mem_ren;
    logic [31:0] mem_raddr;
    logic        mem_wen;
    logic [31:0] mem_waddr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_valid_in;
`ifdef LSU_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int tests_run;
    int tests_failed;
    vec_t vecs[$];

    lsu_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pre_valid  (pre_valid),
        .o_pre_ready  (pre_ready),
        .i_ren        (ren),
        .i_wen        (wen),
        .i_funct3     (funct3),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .i_rd         (rd),
        .o_post_valid (post_valid),
        .i_post_ready (post_ready),
        .o_rdata      (rdata),
        .o_rd         (rd_out),
        .o_mem_valid  (mem_valid_out),
        .o_mem_ren    (mem_ren),
        .o_mem_raddr  (mem_raddr),
        .o_mem_wen    (mem_wen),
        .o_mem_waddr  (mem_waddr),
        .o_mem_wmask  (mem_wmask),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .i_mem_valid  (mem_valid_in)
`ifdef LSU_MISALIGN_CHECK_EN
        ,
        .o_misalign   (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic w, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] md, input logic [4:0] rdv,
                                input logic [31:0] ea, input logic er, input logic ew,
                                input logic [3:0] em, input logic [31:0] ewd,
                                input logic [31:0] erd);
        vec_t v;
        v.ren = r;        v.wen = w;         v.funct3 = f3;
        v.addr = a;       v.wdata = wd;      v.mem_rdata = md;
        v.rd = rdv;       v.exp_addr = ea;   v.exp_ren = er;
        v.exp_wen = ew;   v.exp_wmask = em;  v.exp_wdata = ewd;
        v.exp_rdata = erd;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive a request on a falling edge and hold it until the accepting rising edge.
    task automatic issue(input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rdv);
        @(negedge clk);
        ren = r; wen = w; funct3 = f3; addr = a; wdata = wd; rd = rdv;
        pre_valid = 1'b1;
        checkOutput("pre_ready_idle", pre_ready, 1);
        @(posedge clk);
        @(negedge clk);
        pre_valid = 1'b0;
        ren = ~r; wen = 1'b0; funct3 = 3'b101; addr = ~a; wdata = ~wd; rd = ~rdv;
    endtask

    task automatic applyStimulus(input vec_t v);
        issue(v.ren, v.wen, v.funct3, v.addr, v.wdata, v.rd);
        checkOutput("req_mem_valid", mem_valid_out, 1);
        checkOutput("req_mem_ren", mem_ren, v.exp_ren);
        checkOutput("req_mem_wen", mem_wen, v.exp_wen);
        checkOutput("req_raddr", mem_raddr, v.exp_addr);
        checkOutput("req_waddr", mem_waddr, v.exp_addr);
        checkOutput("req_wmask", mem_wmask, v.exp_wmask);
        checkOutput("req_wdata", mem_wdata, v.exp_wdata);
        checkOutput("req_pre_ready", pre_ready, 0);
        mem_valid_in = 1'b1;
        mem_rdata = 32'h5A5A_5A5A;
        @(negedge clk);
        checkOutput("wait_post_valid", post_valid, 0);
        checkOutput("wait_mem_valid", mem_valid_out, 0);
        checkOutput("wait_waddr", mem_waddr, v.exp_addr);
        checkOutput("wait_wmask", mem_wmask, v.exp_wmask);
        checkOutput("wait_wdata", mem_wdata, v.exp_wdata);
        mem_rdata = v.mem_rdata;
        @(negedge clk);
        mem_valid_in = 1'b0;
        mem_rdata = 32'hA5A5_A5A5;
        checkOutput("resp_post_valid", post_valid, 1);
        checkOutput("resp_rdata", rdata, v.exp_rdata);
        checkOutput("resp_rd", rd_out, v.rd);
        checkOutput("resp_mem_valid", mem_valid_out, 0);
        post_ready = 1'b1;
        @(negedge clk);
        post_ready = 1'b0;
        checkOutput("done_post_valid", post_valid, 0);
        checkOutput("done_pre_ready", pre_ready, 1);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b1;
        pre_valid = 1'b0; ren = 1'b0; wen = 1'b0; funct3 = 3'b000;
        addr = 32'd0; wdata = 32'd0; rd = 5'd0;
        post_ready = 1'b0; mem_rdata = 32'd0; mem_valid_in = 1'b0;

        vecs.push_back(mk(0, 1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 5'd1,
                          32'h8000_0004, 0, 1, 4'b1111, 32'hDEAD_BEEF, 32'h0));
        vecs.push_back(mk(0, 1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 32'h0, 5'd2,
                          32'h8000_0000, 0, 1, 4'b1000, 32'hA500_0000, 32'h0));
        vecs.push_back(mk(1, 0, 3'b000, 32'h8000_0002, 32'h0, 32'h1280_FF34, 5'd3,
                          32'h8000_0000, 1, 0, 4'b0000, 32'h0, 32'hFFFF_FF80));
        vecs.push_back(mk(1, 0, 3'b100, 32'h8000_0002, 32'h0, 32'h1280_FF34, 5'd4,
                          32'h8000_0000, 1, 0, 4'b0000, 32'h0, 32'h0000_0080));
        vecs.push_back(mk(1, 0, 3'b101, 32'h8000_0002, 32'h0, 32'h1280_FF34, 5'd5,
                          32'h8000_0000, 1, 0, 4'b0000, 32'h0, 32'h0000_1280));
        vecs.push_back(mk(1, 0, 3'b001, 32'h8000_0000, 32'h0, 32'h1234_8001, 5'd6,
                          32'h8000_0000, 1, 0, 4'b0000, 32'h0, 32'hFFFF_8001));
        vecs.push_back(mk(1, 0, 3'b010, 32'h8000_0008, 32'h0, 32'hCAFE_BABE, 5'd7,
                          32'h8000_0008, 1, 0, 4'b0000, 32'h0, 32'hCAFE_BABE));
        vecs.push_back(mk(0, 1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 32'h0, 5'd8,
                          32'h8000_0000, 0, 1, 4'b1100, 32'hBEEF_0000, 32'h0));
        vecs.push_back(mk(0, 1, 3'b000, 32'h8000_0001, 32'h1234_5677, 32'h0, 5'd9,
                          32'h8000_0000, 0, 1, 4'b0010, 32'h3456_7700, 32'h0));
        vecs.push_back(mk(1, 1, 3'b010, 32'h0000_0010, 32'h1122_3344, 32'hFFFF_FFFF, 5'd10,
                          32'h0000_0010, 0, 1, 4'b1111, 32'h1122_3344, 32'h0));
        vecs.push_back(mk(1, 0, 3'b000, 32'h8000_0001, 32'h0, 32'h0000_7F00, 5'd11,
                          32'h8000_0000, 1, 0, 4'b0000, 32'h0, 32'h0000_007F));
        vecs.push_back(mk(1, 0, 3'b101, 32'h8000_0000, 32'h0, 32'h0000_8001, 5'd12,
                          32'h8000_0000, 1, 0, 4'b0000, 32'h0, 32'h0000_8001));
`ifndef LSU_MISALIGN_CHECK_EN
        vecs.push_back(mk(1, 0, 3'b010, 32'h8000_0002, 32'h0, 32'h1280_FF34, 5'd13,
                          32'h8000_0000, 1, 0, 4'b0000, 32'h0, 32'h0000_1280));
`endif

        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_pre_ready", pre_ready, 1);
        checkOutput("rst_post_valid", post_valid, 0);
        checkOutput("rst_mem_valid", mem_valid_out, 0);
        checkOutput("rst_wmask", mem_wmask, 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("rst_rd", rd_out, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // Non-memory request answers next cycle with zero data and never touches memory.
        issue(0, 0, 3'b010, 32'h1234_5678, 32'h9999_9999, 5'd17);
        checkOutput("pass_post_valid", post_valid, 1);
        checkOutput("pass_rdata", rdata, 0);
        checkOutput("pass_rd", rd_out, 17);
        checkOutput("pass_mem_valid", mem_valid_out, 0);
`ifdef LSU_MISALIGN_CHECK_EN
        checkOutput("pass_misalign", misalign, 0);
`endif
        post_ready = 1'b1;
        @(negedge clk);
        post_ready = 1'b0;
        checkOutput("pass_done_pre_ready", pre_ready, 1);

        // Slow memory followed by five cycles of writeback backpressure.
        issue(1, 0, 3'b010, 32'h8000_0010, 32'h0, 5'd9);
        checkOutput("bp_mem_valid", mem_valid_out, 1);
        @(negedge clk);
        checkOutput("bp_wait1_post_valid", post_valid, 0);
        @(negedge clk);
        checkOutput("bp_wait2_post_valid", post_valid, 0);
        checkOutput("bp_wait2_mem_valid", mem_valid_out, 0);
        mem_valid_in = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        mem_valid_in = 1'b0;
        mem_rdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_post_valid", post_valid, 1);
            checkOutput("bp_rdata", rdata, 32'h0BAD_F00D);
            checkOutput("bp_rd", rd_out, 9);
            checkOutput("bp_pre_ready", pre_ready, 0);
            @(negedge clk);
        end
        checkOutput("bp_last_post_valid", post_valid, 1);
        post_ready = 1'b1;
        @(negedge clk);
        post_ready = 1'b0;
        checkOutput("bp_done_pre_ready", pre_ready, 1);
        checkOutput("bp_done_post_valid", post_valid, 0);

`ifdef LSU_MISALIGN_CHECK_EN
        // Misaligned word load skips memory and reports the fault.
        issue(1, 0, 3'b010, 32'h8000_0002, 32'h0, 5'd4);
        checkOutput("mis_mem_valid", mem_valid_out, 0);
        checkOutput("mis_post_valid", post_valid, 1);
        checkOutput("mis_flag", misalign, 1);
        @(negedge clk);
        checkOutput("mis_mem_valid2", mem_valid_out, 0);
        checkOutput("mis_rdata", rdata, 0);
        checkOutput("mis_flag2", misalign, 1);
        post_ready = 1'b1;
        @(negedge clk);
        post_ready = 1'b0;
        checkOutput("mis_done_pre_ready", pre_ready, 1);
`endif

        // Reset while waiting on memory, then a stale memory response after release.
        issue(0, 1, 3'b010, 32'h8000_0008, 32'h0000_0055, 5'd3);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_pre_ready", pre_ready, 1);
        checkOutput("abort_post_valid", post_valid, 0);
        checkOutput("abort_mem_valid", mem_valid_out, 0);
        checkOutput("abort_mem_wen", mem_wen, 0);
        checkOutput("abort_wmask", mem_wmask, 0);
        checkOutput("abort_wdata", mem_wdata, 0);
        checkOutput("abort_waddr", mem_waddr, 0);
        checkOutput("abort_rdata", rdata, 0);
        checkOutput("abort_rd", rd_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_valid_in = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("abort_late_post_valid", post_valid, 0);
            checkOutput("abort_late_mem_valid", mem_valid_out, 0);
        end
        mem_valid_in = 1'b0;

        applyStimulus(vecs[2]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
